jt49_bus_master: RTL and testbench

Bus-side sequencer that drives the BDIR/BC1 control pins and 8-bit data bus of an AY-3-8910-style PSG from a simple request/response port. It is the initiator counterpart of the PSG's bus wrapper: a CPU model, test harness or soft-core bridge issues register writes and reads, and this block expands each one into the correct latch-address and write/read pin sequence. An optional address cache skips the latch phase when the target register is already latched.

---
 rtl/jt49_bus_pkg.sv | 22 ++
 rtl/jt49_bus_tmr.sv | 24 ++
 rtl/jt49_bus_master.sv | 164 ++++++++++++++++
 tb/tb_jt49_bus_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt49_bus_pkg.sv
// Shared bus codes and sequencer states for the PSG bus master and the PSG-side wrapper.
package jt49_bus_pkg;

  // {bdir,bc1} pin codes
  localparam logic [1:0] PIN_INACT = 2'b00;
  localparam logic [1:0] PIN_READ  = 2'b01;
  localparam logic [1:0] PIN_WRITE = 2'b10;
  localparam logic [1:0] PIN_LATCH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GAP1,
    ST_XFER,
    ST_GAP2
  } bus_state_e;

  function automatic logic [3:0] phase_load(input int unsigned len);
    return 4'(len - 1);
  endfunction

endpackage

// File: rtl/jt49_bus_tmr.sv
// Loadable 4-bit down-counter; done_o flags the final cycle of a timed phase.
module jt49_bus_tmr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       done_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done_o = (cnt_q == 4'd0);

endmodule

// File: rtl/jt49_bus_master.sv
// Request/response front end that expands PSG register accesses into BDIR/BC1 bus sequences,
// optionally skipping the address latch when the target register is already latched.
module jt49_bus_master
  import jt49_bus_pkg::*;
#(
  parameter int PH         = 3,
  parameter int GAP        = 1,
  parameter int ADDR_CACHE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       bdir,
  output logic       bc1,
  output logic [7:0] bus_dout,
  output logic       bus_oe,
  input  logic [7:0] bus_din
);

  generate
    if (PH < 2 || PH > 15) begin : g_bad_ph
      $error("jt49_bus_master: PH must be within 2..15");
    end
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
      $error("jt49_bus_master: GAP must be within 1..15");
    end
  endgenerate

  localparam logic [3:0] PH_LOAD  = phase_load(PH);
  localparam logic [3:0] GAP_LOAD = phase_load(GAP);

  bus_state_e state_q;
  logic       ready_q;
  logic [1:0] pins_q;
  logic       oe_q;
  logic [7:0] dout_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rd_q;
  logic [3:0] addr_q;
  logic [7:0] data_q;
  logic       cache_vld_q;
  logic [3:0] cache_addr_q;

  logic       handshake;
  logic       cache_hit;
  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_done;

  assign handshake = req_valid && ready_q;
  assign cache_hit = (ADDR_CACHE != 0) && cache_vld_q && (cache_addr_q == req_addr);

  // The counter is reloaded on every state exit with the length of the state being entered:
  // LATCH and XFER are always followed by a gap, everything else by an active phase.
  assign tmr_load = (state_q == ST_IDLE) ? handshake : tmr_done;
  assign tmr_val  = (state_q == ST_LATCH || state_q == ST_XFER) ? GAP_LOAD : PH_LOAD;

  jt49_bus_tmr u_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      pins_q       <= PIN_INACT;
      oe_q         <= 1'b0;
      dout_q       <= 8'h00;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'h00;
      rd_q         <= 1'b0;
      addr_q       <= 4'h0;
      data_q       <= 8'h00;
      cache_vld_q  <= 1'b0;
      cache_addr_q <= 4'h0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (handshake) begin
            ready_q <= 1'b0;
            rd_q    <= req_rd;
            addr_q  <= req_addr;
            data_q  <= req_data;
            if (cache_hit) begin
              state_q <= ST_XFER;
              pins_q  <= req_rd ? PIN_READ : PIN_WRITE;
              oe_q    <= !req_rd;
              dout_q  <= req_rd ? 8'h00 : req_data;
            end else begin
              state_q <= ST_LATCH;
              pins_q  <= PIN_LATCH;
              oe_q    <= 1'b1;
              dout_q  <= {4'h0, req_addr};
            end
          end
        end
        ST_LATCH: begin
          if (tmr_done) begin
            state_q      <= ST_GAP1;
            pins_q       <= PIN_INACT;
            oe_q         <= 1'b0;
            dout_q       <= 8'h00;
            cache_vld_q  <= 1'b1;
            cache_addr_q <= addr_q;
          end
        end
        ST_GAP1: begin
          if (tmr_done) begin
            state_q <= ST_XFER;
            pins_q  <= rd_q ? PIN_READ : PIN_WRITE;
            oe_q    <= !rd_q;
            dout_q  <= rd_q ? 8'h00 : data_q;
          end
        end
        ST_XFER: begin
          if (tmr_done) begin
            state_q <= ST_GAP2;
            pins_q  <= PIN_INACT;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
            if (rd_q) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= bus_din;
            end
          end
        end
        ST_GAP2: begin
          if (tmr_done) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pins_q  <= PIN_INACT;
          oe_q    <= 1'b0;
          dout_q  <= 8'h00;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign bdir      = pins_q[1];
  assign bc1       = pins_q[0];
  assign bus_oe    = oe_q;
  assign bus_dout  = dout_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jt49_bus_master.sv
// Bench for jt49_bus_master: two configurations, each with a toy PSG register file on the bus
// and a timeline model that predicts every output on every cycle.
module tb_jt49_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_rd;
  logic [1:0][3:0] req_addr;
  logic [1:0][7:0] req_data;
  logic [1:0]      rsp_valid;
  logic [1:0][7:0] rsp_data;
  logic [1:0]      bdir;
  logic [1:0]      bc1;
  logic [1:0][7:0] bus_dout;
  logic [1:0]      bus_oe;
  logic [1:0][7:0] bus_din;

  int tests = 0;
  int fails = 0;

  logic [1:0] lp [0:31];
  logic [7:0] ld [0:31];
  logic       lo [0:31];
  logic       lr [0:31];

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Instance 0: PH=3 GAP=1 cache on. Instance 1: PH=2 GAP=3 cache off.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sb
    localparam int P = (gi == 0) ? 3 : 2;
    localparam int G = (gi == 0) ? 1 : 3;
    localparam bit C = (gi == 0);

    jt49_bus_master #(.PH(P), .GAP(G), .ADDR_CACHE(C ? 1 : 0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[gi]),
      .req_valid (req_valid[gi]),
      .req_ready (req_ready[gi]),
      .req_rd    (req_rd[gi]),
      .req_addr  (req_addr[gi]),
      .req_data  (req_data[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_data  (rsp_data[gi]),
      .bdir      (bdir[gi]),
      .bc1       (bc1[gi]),
      .bus_dout  (bus_dout[gi]),
      .bus_oe    (bus_oe[gi]),
      .bus_din   (bus_din[gi])
    );

    // Toy PSG: latches an address on 11, stores bus data on 10, always presents the latched register.
    logic [7:0] psg_regs [16];
    logic [3:0] psg_addr;
    always @(posedge clk) begin
      if ({bdir[gi], bc1[gi]} == 2'b11) psg_addr <= bus_dout[gi][3:0];
      else if ({bdir[gi], bc1[gi]} == 2'b10) psg_regs[psg_addr] <= bus_dout[gi];
    end
    assign bus_din[gi] = psg_regs[psg_addr];

    typedef struct packed {
      logic       rdy;
      logic [1:0] pins;
      logic       oe;
      logic [7:0] dout;
      logic       rsp;
      logic [7:0] rdata;
      logic       rst;
    } rec_t;

    function automatic rec_t mk(input logic [1:0] p, input logic oe, input logic [7:0] dv);
      rec_t r;
      r = '0;
      r.pins = p;
      r.oe = oe;
      r.dout = dv;
      return r;
    endfunction

    rec_t       q[$];
    rec_t       cur;
    rec_t       r;
    bit         started = 0;
    bit         hit;
    logic       mc_v;
    logic [3:0] mc_a;
    logic [7:0] mregs [16];
    logic [7:0] last_rd;

    always @(negedge clk) begin
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur = '0;
        cur.rdy = 1'b1;
      end
      if (started) begin
        if (cur.rst) last_rd = 8'h00;
        if (cur.rsp) last_rd = cur.rdata;
        check("cycle{rdy,pins,oe,dout,rsp,rdata}", gi,
              {11'd0, req_ready[gi], bdir[gi], bc1[gi], bus_oe[gi], bus_dout[gi], rsp_valid[gi], rsp_data[gi]},
              {11'd0, cur.rdy, cur.pins, cur.oe, cur.dout, cur.rsp, last_rd});
      end
      if (!rst_n[gi]) begin
        q.delete();
        r = '0;
        r.rst = 1'b1;
        q.push_back(r);
        mc_v = 1'b0;
        started = 1;
      end else if (started && cur.rdy && req_valid[gi]) begin
        hit = C && mc_v && (mc_a == req_addr[gi]);
        if (!hit) begin
          for (int i = 0; i < P; i++) q.push_back(mk(2'b11, 1'b1, {4'h0, req_addr[gi]}));
          for (int i = 0; i < G; i++) q.push_back(mk(2'b00, 1'b0, 8'h00));
          mc_v = 1'b1;
          mc_a = req_addr[gi];
        end
        for (int i = 0; i < P; i++)
          q.push_back(req_rd[gi] ? mk(2'b01, 1'b0, 8'h00) : mk(2'b10, 1'b1, req_data[gi]));
        for (int i = 0; i < G; i++) begin
          r = mk(2'b00, 1'b0, 8'h00);
          if (i == 0 && req_rd[gi]) begin
            r.rsp = 1'b1;
            r.rdata = mregs[req_addr[gi]];
          end
          q.push_back(r);
        end
        if (!req_rd[gi]) mregs[req_addr[gi]] = req_data[gi];
      end
    end
  end

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    while (!req_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout inst%0d: got req_ready=0, expected 1 within 50 cycles", k);
    end
  endtask

  // Issue one request, log pins/bus per busy cycle (index = cycles after the handshake).
  task automatic do_req(input int k, input logic rd, input logic [3:0] a, input logic [7:0] d,
                        output int busy);
    int n;
    req_valid[k] = 1'b1;
    req_rd[k]    = rd;
    req_addr[k]  = a;
    req_data[k]  = d;
    wait_ready(k);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    req_rd[k]    = 1'b0;
    req_addr[k]  = 4'h0;
    req_data[k]  = 8'h00;
    for (int i = 0; i < 32; i++) begin
      lp[i] = 2'b00; ld[i] = 8'h00; lo[i] = 1'b0; lr[i] = 1'b0;
    end
    busy = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (req_ready[k]) break;
      busy++;
      if (busy < 32) begin
        lp[busy] = {bdir[k], bc1[k]};
        ld[busy] = bus_dout[k];
        lo[busy] = bus_oe[k];
        lr[busy] = rsp_valid[k];
      end
      n++;
    end
    $display("[TB] inst%0d %s addr=%0h data=%02h busy=%0d rsp_data=%02h",
             k, rd ? "read " : "write", a, d, busy, rsp_data[k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;
    int hs;
    int idx;
    rst_n = 2'b00; req_valid = '0; req_rd = '0; req_addr = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 2'b11;
    @(negedge clk);
    check("ready_last_reset_cycle", 0, {31'd0, req_ready[0]}, 32'd0);
    @(negedge clk);
    check("ready_after_reset", 0, {31'd0, req_ready[0]}, 32'd1);
    check("ready_after_reset", 1, {31'd0, req_ready[1]}, 32'd1);

    // Full write, defaults
    do_req(0, 1'b0, 4'h7, 8'h38, busy);
    check("full_write_busy", 0, busy, 8);
    check("latch_pins_c2", 0, {30'd0, lp[2]}, 32'h3);
    check("latch_bus_c2", 0, {24'd0, ld[2]}, 32'h07);
    check("gap1_pins_c4", 0, {30'd0, lp[4]}, 32'h0);
    check("write_pins_c6", 0, {30'd0, lp[6]}, 32'h2);
    check("write_bus_c6", 0, {24'd0, ld[6]}, 32'h38);
    check("psg_reg7", 0, {24'd0, g_sb[0].psg_regs[7]}, 32'h38);

    // Cache hit, back-to-back
    do_req(0, 1'b0, 4'h7, 8'h38, busy);
    check("cached_write_busy", 0, busy, 4);
    check("cached_write_pins_c1", 0, {30'd0, lp[1]}, 32'h2);
    do_req(0, 1'b0, 4'h8, 8'h11, busy);
    check("new_addr_busy", 0, busy, 8);
    check("new_addr_latch_c1", 0, {30'd0, lp[1]}, 32'h3);

    // Reads: cached read of reg 0, then full read of reg 7
    do_req(0, 1'b0, 4'h0, 8'h5A, busy);
    do_req(0, 1'b1, 4'h0, 8'h00, busy);
    check("cached_read_busy", 0, busy, 4);
    check("cached_read_pins_c1", 0, {30'd0, lp[1]}, 32'h1);
    check("cached_read_rsp_c4", 0, {31'd0, lr[4]}, 32'd1);
    check("cached_read_data", 0, {24'd0, rsp_data[0]}, 32'h5A);
    do_req(0, 1'b1, 4'h7, 8'h00, busy);
    check("full_read_pins_c6", 0, {30'd0, lp[6]}, 32'h1);
    check("full_read_oe_c6", 0, {31'd0, lo[6]}, 32'd0);
    check("full_read_rsp_c8", 0, {31'd0, lr[8]}, 32'd1);
    check("full_read_data", 0, {24'd0, rsp_data[0]}, 32'h38);

    // Backpressure: three writes queued behind a held req_valid
    hs = 0;
    idx = 0;
    req_valid[0] = 1'b1; req_rd[0] = 1'b0; req_addr[0] = 4'h1; req_data[0] = 8'h11;
    for (int n = 0; n < 100 && idx < 3; n++) begin
      @(negedge clk);
      if (req_ready[0] && req_valid[0]) begin
        hs++;
        idx++;
        $display("[TB] inst0 queued write #%0d addr=%0h data=%02h", idx, req_addr[0], req_data[0]);
        @(posedge clk);
        #1;
        if (idx < 3) begin
          req_addr[0] = 4'(idx + 1);
          req_data[0] = 8'(8'h11 * (idx + 1));
        end else begin
          req_valid[0] = 1'b0;
        end
      end
    end
    check("backpressure_handshakes", 0, hs, 3);
    wait_ready(0);

    // Reset in the middle of LATCH, then previously cached addr 3 must latch again
    req_valid[0] = 1'b1; req_rd[0] = 1'b0; req_addr[0] = 4'h9; req_data[0] = 8'h99;
    wait_ready(0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("abort_latch_pins_c2", 0, {30'd0, bdir[0], bc1[0]}, 32'h3);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("abort_pins_c3", 0, {30'd0, bdir[0], bc1[0]}, 32'h0);
    check("abort_oe_c3", 0, {31'd0, bus_oe[0]}, 32'd0);
    $display("[TB] inst0 write addr=9 data=99 aborted by reset");
    do_req(0, 1'b0, 4'h3, 8'h33, busy);
    check("post_reset_busy", 0, busy, 8);
    check("post_reset_latch_c1", 0, {30'd0, lp[1]}, 32'h3);
    do_req(0, 1'b0, 4'h9, 8'h99, busy);
    check("post_reset_same_addr_latch", 0, {30'd0, lp[1]}, 32'h3);

    // PH=2, GAP=3, cache off
    do_req(1, 1'b0, 4'h4, 8'hC3, busy);
    check("sweep_busy", 1, busy, 10);
    check("sweep_latch_c2", 1, {30'd0, lp[2]}, 32'h3);
    check("sweep_gap1_c3", 1, {30'd0, lp[3]}, 32'h0);
    check("sweep_gap1_c5", 1, {30'd0, lp[5]}, 32'h0);
    check("sweep_write_c6", 1, {30'd0, lp[6]}, 32'h2);
    check("sweep_write_c7", 1, {24'd0, ld[7]}, 32'hC3);
    check("sweep_gap2_c8", 1, {30'd0, lp[8]}, 32'h0);
    do_req(1, 1'b0, 4'h4, 8'h3C, busy);
    check("sweep_nocache_busy", 1, busy, 10);
    check("sweep_nocache_latch_c1", 1, {30'd0, lp[1]}, 32'h3);
    do_req(1, 1'b1, 4'h4, 8'h00, busy);
    check("sweep_read_rsp_c8", 1, {31'd0, lr[8]}, 32'd1);
    check("sweep_read_data", 1, {24'd0, rsp_data[1]}, 32'h3C);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
